dds_symbol_scheduler: RTL and testbench

//  Sequences the DDS datapath for digital modulation. Accepts a stream of 1-2 bit symbols over a

---
 rtl/dds_pkg.sv | 35 +++
 rtl/dds_symbol_scheduler_if.sv | 12 +
 rtl/sym_timer.sv | 27 ++
 rtl/dds_symbol_scheduler.sv | 153 +++++++++++++++
 tb/tb_dds_symbol_scheduler.sv | 313 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dds_pkg.sv
// Shared types and phase constants for the DDS symbol scheduler.
// Phase constants are expressed at the reference width and rescaled by users.
package dds_pkg;

   localparam int DDS_PHASE_W = 8;

   typedef enum logic [1:0] {
      MODE_BFSK = 2'b00,
      MODE_BPSK = 2'b01,
      MODE_QPSK = 2'b10,
      MODE_RSVD = 2'b11
   } mode_e;

   typedef enum logic [2:0] {
      IDLE,
      PRIME,
      RUN,
      GAP,
      DONE
   } state_e;

   localparam logic [DDS_PHASE_W-1:0] PH_90  = DDS_PHASE_W'(1) << (DDS_PHASE_W - 2);
   localparam logic [DDS_PHASE_W-1:0] PH_180 = PH_90 << 1;
   localparam logic [DDS_PHASE_W-1:0] PH_270 = PH_90 + PH_180;

   function automatic logic [DDS_PHASE_W-1:0] quadrant_phase(input logic [1:0] quad);
      case (quad)
         2'd1:    return PH_90;
         2'd2:    return PH_180;
         2'd3:    return PH_270;
         default: return '0;
      endcase
   endfunction

endpackage

// File: rtl/dds_symbol_scheduler_if.sv
// Symbol stream between the symbol source (master) and the scheduler (slave).
interface dds_symbol_scheduler_if;

   logic       sym_valid;
   logic [1:0] sym_data;
   logic       sym_last;
   logic       sym_ready;

   modport master (output sym_valid, output sym_data, output sym_last, input sym_ready);
   modport slave  (input sym_valid, input sym_data, input sym_last, output sym_ready);

endinterface

// File: rtl/sym_timer.sv
// Loadable samples-per-symbol down-counter; holds at zero until reloaded.
module sym_timer #(
   parameter int CNT_W = 10
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic             dec,
   input  logic [CNT_W-1:0] load_val,
   output logic [CNT_W-1:0] cnt,
   output logic             zero
);

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= load_val;
      end else if (dec && (cnt != '0)) begin
         cnt <= cnt - CNT_W'(1);
      end
   end

   assign zero = (cnt == '0);

endmodule

// File: rtl/dds_symbol_scheduler.sv
// Holds each modulation symbol for a programmable number of samples and drives
// the DDS frequency word, phase offset and accumulator enable/clear.
module dds_symbol_scheduler
   import dds_pkg::*;
#(
   parameter int PHASE_W = DDS_PHASE_W,
   parameter int CNT_W   = 10
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [1:0]             mode,
   input  logic [PHASE_W-1:0]     f0_word,
   input  logic [PHASE_W-1:0]     f1_word,
   input  logic [CNT_W-1:0]       sym_len,
   input  logic                   start,
   input  logic                   abort,
   dds_symbol_scheduler_if.slave  sym,
   output logic                   dds_en,
   output logic                   dds_clr,
   output logic [PHASE_W-1:0]     freq_word,
   output logic [PHASE_W-1:0]     phase_off,
   output logic                   sym_strobe,
   output logic                   busy,
   output logic                   done,
   output logic                   underrun
);

   state_e             state_q, state_d;
   mode_e              mode_q;
   logic [PHASE_W-1:0] f0_q, f1_q;
   logic [CNT_W-1:0]   len_q;
   logic               last_q;

   logic               cfg_ld, ld_sym, dec, clr_d, und_d, sym_hs;
   logic [CNT_W-1:0]   cnt;
   logic               cnt_zero;
   logic [PHASE_W-1:0] map_freq, map_off;
   logic [1:0]         map_quad;

   sym_timer #(.CNT_W(CNT_W)) u_timer (
      .clk      (clk),
      .rst      (rst),
      .load     (ld_sym),
      .dec      (dec),
      .load_val (len_q - CNT_W'(1)),
      .cnt      (cnt),
      .zero     (cnt_zero)
   );

   // Ready comes only from state and counter so the source never sees a combinational loop.
   assign sym.sym_ready = !abort &&
                          ((state_q == PRIME) || (state_q == GAP) ||
                           ((state_q == RUN) && cnt_zero && !last_q));
   assign sym_hs = sym.sym_ready && sym.sym_valid;

   // NOTE: every combinational output gets a default first, so no path can infer a latch.
   always_comb begin
      map_freq = f0_q;
      map_quad = 2'b00;
      case (mode_q)
         MODE_BFSK: map_freq = sym.sym_data[0] ? f1_q : f0_q;
         MODE_BPSK: map_quad = {sym.sym_data[0], 1'b0};
         MODE_QPSK: map_quad = sym.sym_data;
         default:   ;
      endcase
   end

   // Quadrant phase sits in the MSBs whatever PHASE_W is.
   assign map_off = PHASE_W'({quadrant_phase(map_quad), {PHASE_W{1'b0}}} >> DDS_PHASE_W);

   always_comb begin
      state_d = state_q;
      cfg_ld  = 1'b0;
      ld_sym  = 1'b0;
      dec     = 1'b0;
      clr_d   = 1'b0;
      und_d   = underrun;
      if (abort && (state_q != IDLE)) begin
         state_d = IDLE;
         clr_d   = 1'b1;
      end else begin
         case (state_q)
            IDLE: begin
               if (start && !abort && (mode != MODE_RSVD)) begin
                  state_d = PRIME;
                  cfg_ld  = 1'b1;
                  clr_d   = 1'b1;
                  und_d   = 1'b0;
               end
            end
            PRIME, GAP: begin
               if (sym_hs) begin
                  ld_sym  = 1'b1;
                  state_d = RUN;
               end
            end
            RUN: begin
               if (!cnt_zero) begin
                  dec = 1'b1;
               end else if (last_q) begin
                  state_d = DONE;
               end else if (sym_hs) begin
                  ld_sym = 1'b1;
               end else begin
                  state_d = GAP;
                  und_d   = 1'b1;
               end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q    <= IDLE;
         mode_q     <= MODE_BFSK;
         f0_q       <= '0;
         f1_q       <= '0;
         len_q      <= '0;
         last_q     <= 1'b0;
         dds_en     <= 1'b0;
         dds_clr    <= 1'b0;
         freq_word  <= '0;
         phase_off  <= '0;
         sym_strobe <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         underrun   <= 1'b0;
      end else begin
         state_q    <= state_d;
         dds_en     <= (state_d == RUN);
         dds_clr    <= clr_d;
         sym_strobe <= ld_sym;
         busy       <= (state_d != IDLE);
         done       <= (state_d == DONE);
         underrun   <= und_d;
         if (cfg_ld) begin
            mode_q <= mode_e'(mode);
            f0_q   <= f0_word;
            f1_q   <= f1_word;
            len_q  <= (sym_len == '0) ? CNT_W'(1) : sym_len;
         end
         if (ld_sym) begin
            freq_word <= map_freq;
            phase_off <= map_off;
            last_q    <= sym.sym_last;
         end
      end
   end

endmodule

// File: tb/tb_dds_symbol_scheduler.sv
// Directed self-checking bench for dds_symbol_scheduler with hand-computed expectations.
module tb_dds_symbol_scheduler;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [1:0] mode = 2'b00;
   logic [7:0] f0_word = '0, f1_word = '0;
   logic [9:0] sym_len = '0;
   logic       start = 1'b0, abort = 1'b0;
   logic       dds_en, dds_clr, sym_strobe, busy, done, underrun;
   logic [7:0] freq_word, phase_off;

   dds_symbol_scheduler_if sym_if ();

   dds_symbol_scheduler #(.PHASE_W(8), .CNT_W(10)) dut (
      .clk        (clk),
      .rst        (rst),
      .mode       (mode),
      .f0_word    (f0_word),
      .f1_word    (f1_word),
      .sym_len    (sym_len),
      .start      (start),
      .abort      (abort),
      .sym        (sym_if),
      .dds_en     (dds_en),
      .dds_clr    (dds_clr),
      .freq_word  (freq_word),
      .phase_off  (phase_off),
      .sym_strobe (sym_strobe),
      .busy       (busy),
      .done       (done),
      .underrun   (underrun)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   logic [1:0] syms [8];
   int         nsyms;
   logic       en_log [32], clr_log [32], stb_log [32], done_log [32];
   logic       busy_log [32], rdy_log [32], und_log [32];
   logic [7:0] frq_log [32], off_log [32];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Starts a burst, then records outputs for ncyc cycles while the source
   // offers symbols whenever vmask[k] is set; cycle 0 is the one after start.
   task automatic run_burst(input logic [1:0] m, input logic [7:0] f0, input logic [7:0] f1,
                            input logic [9:0] len, input int ncyc, input logic [31:0] vmask,
                            input int abort_at);
      int   idx;
      logic hs;
      idx     = 0;
      mode    = m;
      f0_word = f0;
      f1_word = f1;
      sym_len = len;
      start   = 1'b1;
      tick();
      start   = 1'b0;
      for (int k = 0; k < ncyc; k++) begin
         abort            = (k == abort_at);
         sym_if.sym_valid = vmask[k] && (idx < nsyms);
         sym_if.sym_data  = (idx < nsyms) ? syms[idx] : 2'b00;
         sym_if.sym_last  = (idx == nsyms - 1);
         #1;
         en_log[k]   = dds_en;
         clr_log[k]  = dds_clr;
         stb_log[k]  = sym_strobe;
         done_log[k] = done;
         busy_log[k] = busy;
         rdy_log[k]  = sym_if.sym_ready;
         und_log[k]  = underrun;
         frq_log[k]  = freq_word;
         off_log[k]  = phase_off;
         hs = sym_if.sym_ready && sym_if.sym_valid;
         tick();
         if (hs) idx++;
      end
      abort            = 1'b0;
      sym_if.sym_valid = 1'b0;
      sym_if.sym_last  = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      tick();
      tick();
      n_vec++;
      if ({dds_en, dds_clr, sym_strobe, busy, done, underrun, sym_if.sym_ready} !== 7'b0 ||
          freq_word !== 8'h00 || phase_off !== 8'h00) begin
         n_err++;
         $display("FAIL reset_outputs got en=%b clr=%b stb=%b busy=%b done=%b und=%b rdy=%b freq=%h off=%h, all required 0",
                  dds_en, dds_clr, sym_strobe, busy, done, underrun, sym_if.sym_ready, freq_word, phase_off);
      end
      rst = 1'b1;
      tick();
      syms[0] = 2'd2; syms[1] = 2'd1; nsyms = 2;
      run_burst(2'b10, 8'h37, 8'h00, 10'd5, 3, '1, -1);
      n_vec++;
      if (dds_en !== 1'b1 || phase_off !== 8'h80) begin
         n_err++;
         $display("FAIL reset_prerun got en=%b off=%h required en=1 off=80", dds_en, phase_off);
      end
      rst = 1'b0;
      tick();
      rst = 1'b1;
      n_vec++;
      if ({dds_en, dds_clr, sym_strobe, busy, done, underrun, sym_if.sym_ready} !== 7'b0 ||
          freq_word !== 8'h00 || phase_off !== 8'h00) begin
         n_err++;
         $display("FAIL reset_midrun got en=%b clr=%b stb=%b busy=%b done=%b und=%b rdy=%b freq=%h off=%h, all required 0",
                  dds_en, dds_clr, sym_strobe, busy, done, underrun, sym_if.sym_ready, freq_word, phase_off);
      end
      tick();
      n_vec++;
      if (busy !== 1'b0 || dds_en !== 1'b0) begin
         n_err++;
         $display("FAIL reset_stays_idle got busy=%b en=%b required 0 0", busy, dds_en);
      end
   endtask

   task automatic test_bpsk();
      syms[0] = 2'd1; syms[1] = 2'd0; syms[2] = 2'd1; nsyms = 3;
      run_burst(2'b01, 8'h21, 8'h33, 10'd4, 15, '1, -1);
      for (int k = 0; k < 15; k++) begin
         logic       e_en;
         logic [7:0] e_off;
         e_en  = (k >= 1 && k <= 12);
         e_off = (k >= 5 && k <= 8) ? 8'h00 : 8'h80;
         n_vec++;
         if (en_log[k] !== e_en) begin
            n_err++; $display("FAIL bpsk_en[%0d] got %b required %b", k, en_log[k], e_en);
         end
         if (e_en) begin
            n_vec++;
            if (off_log[k] !== e_off || frq_log[k] !== 8'h21) begin
               n_err++;
               $display("FAIL bpsk_word[%0d] got off=%h freq=%h required off=%h freq=21", k, off_log[k], frq_log[k], e_off);
            end
         end
         n_vec++;
         if (stb_log[k] !== (k == 1 || k == 5 || k == 9) || done_log[k] !== (k == 13) ||
             clr_log[k] !== (k == 0) || busy_log[k] !== (k <= 13)) begin
            n_err++;
            $display("FAIL bpsk_ctrl[%0d] got stb=%b done=%b clr=%b busy=%b required %b %b %b %b", k,
                     stb_log[k], done_log[k], clr_log[k], busy_log[k],
                     (k == 1 || k == 5 || k == 9), (k == 13), (k == 0), (k <= 13));
         end
      end
   endtask

   task automatic test_qpsk();
      syms[0] = 2'd3; syms[1] = 2'd1; syms[2] = 2'd2; nsyms = 3;
      run_burst(2'b10, 8'h11, 8'h22, 10'd2, 9, '1, -1);
      for (int k = 0; k < 9; k++) begin
         logic       e_en;
         logic [7:0] e_off;
         e_en  = (k >= 1 && k <= 6);
         e_off = (k <= 2) ? 8'hC0 : (k <= 4) ? 8'h40 : 8'h80;
         n_vec++;
         if (en_log[k] !== e_en || done_log[k] !== (k == 7)) begin
            n_err++;
            $display("FAIL qpsk_en[%0d] got en=%b done=%b required %b %b", k, en_log[k], done_log[k], e_en, (k == 7));
         end
         if (e_en) begin
            n_vec++;
            if (off_log[k] !== e_off || frq_log[k] !== 8'h11) begin
               n_err++;
               $display("FAIL qpsk_word[%0d] got off=%h freq=%h required off=%h freq=11", k, off_log[k], frq_log[k], e_off);
            end
         end
      end
   endtask

   task automatic test_underrun();
      syms[0] = 2'd1; syms[1] = 2'd0; nsyms = 2;
      run_burst(2'b00, 8'd5, 8'd9, 10'd3, 11, 32'hFFFF_FFE1, -1);
      for (int k = 0; k < 11; k++) begin
         logic       e_en, e_rdy;
         logic [7:0] e_frq;
         e_en  = (k >= 1 && k <= 3) || (k >= 6 && k <= 8);
         e_frq = (k <= 5) ? 8'd9 : 8'd5;
         e_rdy = (k == 0) || (k == 3) || (k == 4) || (k == 5);
         n_vec++;
         if (en_log[k] !== e_en || rdy_log[k] !== e_rdy || und_log[k] !== (k >= 4)) begin
            n_err++;
            $display("FAIL gap_ctrl[%0d] got en=%b rdy=%b und=%b required %b %b %b", k,
                     en_log[k], rdy_log[k], und_log[k], e_en, e_rdy, (k >= 4));
         end
         if (k >= 1 && k <= 8) begin
            n_vec++;
            if (frq_log[k] !== e_frq || stb_log[k] !== (k == 1 || k == 6)) begin
               n_err++;
               $display("FAIL gap_freq[%0d] got freq=%0d stb=%b required %0d %b", k, frq_log[k], stb_log[k], e_frq, (k == 1 || k == 6));
            end
         end
      end
      n_vec++;
      if (done_log[9] !== 1'b1 || underrun !== 1'b1) begin
         n_err++;
         $display("FAIL gap_done got done=%b und=%b required 1 1", done_log[9], underrun);
      end
   endtask

   task automatic test_abort();
      syms[0] = 2'd1; syms[1] = 2'd0; syms[2] = 2'd1; nsyms = 3;
      run_burst(2'b01, 8'h44, 8'h00, 10'd4, 12, '1, 6);
      n_vec++;
      if (und_log[0] !== 1'b0 || clr_log[0] !== 1'b1) begin
         n_err++;
         $display("FAIL abort_start got und=%b clr=%b required 0 1", und_log[0], clr_log[0]);
      end
      n_vec++;
      if (rdy_log[6] !== 1'b0) begin
         n_err++; $display("FAIL abort_ready got %b required 0", rdy_log[6]);
      end
      n_vec++;
      if (en_log[7] !== 1'b0 || clr_log[7] !== 1'b1 || busy_log[7] !== 1'b0) begin
         n_err++;
         $display("FAIL abort_next got en=%b clr=%b busy=%b required 0 1 0", en_log[7], clr_log[7], busy_log[7]);
      end
      for (int k = 0; k < 12; k++) begin
         n_vec++;
         if (done_log[k] !== 1'b0 || en_log[k] !== (k >= 1 && k <= 6) || clr_log[k] !== (k == 0 || k == 7)) begin
            n_err++;
            $display("FAIL abort_seq[%0d] got done=%b en=%b clr=%b required 0 %b %b", k,
                     done_log[k], en_log[k], clr_log[k], (k >= 1 && k <= 6), (k == 0 || k == 7));
         end
      end
   endtask

   task automatic test_short_len();
      logic [7:0] e_frq [4];
      logic [7:0] e_off [4];
      e_frq[0] = 8'd3; e_frq[1] = 8'd7; e_frq[2] = 8'd7; e_frq[3] = 8'd3;
      e_off[0] = 8'h80; e_off[1] = 8'h00; e_off[2] = 8'h00; e_off[3] = 8'h80;
      for (int pass = 0; pass < 2; pass++) begin
         if (pass == 0) begin
            syms[0] = 2'd0; syms[1] = 2'd1; syms[2] = 2'd1; syms[3] = 2'd0; nsyms = 4;
            run_burst(2'b00, 8'd3, 8'd7, 10'd0, 7, '1, -1);
         end else begin
            syms[0] = 2'd1; syms[1] = 2'd0; syms[2] = 2'd0; syms[3] = 2'd1; nsyms = 4;
            run_burst(2'b01, 8'd3, 8'd7, 10'd1, 7, '1, -1);
         end
         for (int k = 0; k < 7; k++) begin
            n_vec++;
            if (en_log[k] !== (k >= 1 && k <= 4) || stb_log[k] !== (k >= 1 && k <= 4) ||
                rdy_log[k] !== (k <= 3) || done_log[k] !== (k == 5)) begin
               n_err++;
               $display("FAIL short%0d_ctrl[%0d] got en=%b stb=%b rdy=%b done=%b required %b %b %b %b", pass, k,
                        en_log[k], stb_log[k], rdy_log[k], done_log[k],
                        (k >= 1 && k <= 4), (k >= 1 && k <= 4), (k <= 3), (k == 5));
            end
            if (k >= 1 && k <= 4) begin
               n_vec++;
               if ((pass == 0 && frq_log[k] !== e_frq[k-1]) ||
                   (pass == 1 && (off_log[k] !== e_off[k-1] || frq_log[k] !== 8'd3))) begin
                  n_err++;
                  $display("FAIL short%0d_word[%0d] got freq=%0d off=%h", pass, k, frq_log[k], off_log[k]);
               end
            end
         end
      end
   endtask

   task automatic test_ignored_start();
      mode  = 2'b11;
      start = 1'b1;
      tick();
      start = 1'b0;
      n_vec++;
      if (busy !== 1'b0 || dds_clr !== 1'b0) begin
         n_err++; $display("FAIL rsvd_start got busy=%b clr=%b required 0 0", busy, dds_clr);
      end
      tick();
      n_vec++;
      if (busy !== 1'b0) begin
         n_err++; $display("FAIL rsvd_idle got busy=%b required 0", busy);
      end
      mode  = 2'b00;
      start = 1'b1;
      abort = 1'b1;
      tick();
      start = 1'b0;
      abort = 1'b0;
      n_vec++;
      if (busy !== 1'b0 || dds_clr !== 1'b0) begin
         n_err++; $display("FAIL abort_with_start got busy=%b clr=%b required 0 0", busy, dds_clr);
      end
   endtask

   initial begin
      sym_if.sym_valid = 1'b0;
      sym_if.sym_data  = 2'b00;
      sym_if.sym_last  = 1'b0;
      test_reset();
      test_bpsk();
      test_qpsk();
      test_underrun();
      test_abort();
      test_short_len();
      test_ignored_start();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
